// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch port, the load/store port and the memory macro.
// The slave view belongs to the arbiter; the master view belongs to the requesters and the memory model.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [BE_W-1:0]   d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [BE_W-1:0]   mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store, one access in flight.
// Data wins ties; a starvation counter forces a fetch grant after STARVE_MAX consecutive data wins.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_port_arbiter_if.slave     bus,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic [2:0]        lat_cnt;
  logic [3:0]        starve_cnt;
  logic              owner_d;
  logic              owner_we;
  logic              if_rvalid_q, d_rvalid_q;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;

  logic arb, fetch_forced, grant_d, grant_f, capture;

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    arb          = reset && (state == IDLE || state == RESP);
    fetch_forced = bus.if_req && (starve_cnt == 4'(STARVE_MAX));
    grant_d      = arb && bus.d_req && !fetch_forced;
    grant_f      = arb && bus.if_req && !grant_d;
    capture      = (state == WAIT) && (lat_cnt == 3'd0);

    bus.if_gnt    = grant_f;
    bus.d_gnt     = grant_d;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_be    = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (grant_d) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.d_we;
      bus.mem_be    = bus.d_be;
      bus.mem_addr  = bus.d_addr;
      bus.mem_wdata = bus.d_wdata;
    end else if (grant_f) begin
      bus.mem_en   = 1'b1;
      bus.mem_be   = '1;
      bus.mem_addr = bus.if_addr;
    end

    state_nxt = state;
    unique case (state)
      IDLE:    if (grant_d || grant_f) state_nxt = WAIT;
      WAIT:    if (capture) state_nxt = RESP;
      RESP:    state_nxt = (grant_d || grant_f) ? WAIT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      lat_cnt     <= 3'd0;
      starve_cnt  <= 4'd0;
      owner_d     <= 1'b0;
      owner_we    <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state       <= state_nxt;
      if_rvalid_q <= capture && !owner_d;
      d_rvalid_q  <= capture && owner_d;

      if (grant_d || grant_f) begin
        owner_d  <= grant_d;
        owner_we <= grant_d && bus.d_we;
        lat_cnt  <= 3'(MEM_LAT - 1);
      end else if (state == WAIT && lat_cnt != 3'd0) begin
        lat_cnt <= lat_cnt - 3'd1;
      end

      // Store acks return zero data; the memory bus value is ignored for writes.
      if (capture) begin
        if (owner_d) d_rdata_q  <= owner_we ? '0 : bus.mem_rdata;
        else         if_rdata_q <= bus.mem_rdata;
      end

      if (arb) begin
        if (!bus.if_req || grant_f)                    starve_cnt <= 4'd0;
        else if (grant_d && starve_cnt != 4'(STARVE_MAX)) starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

  assign bus.if_rvalid = if_rvalid_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter at MEM_LAT=2, STARVE_MAX=4.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  int   total = 0;
  int   bad   = 0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic probe();
    @(negedge clk);
  endtask

  task automatic clear();
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_be      = '0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.mem_rdata = '0;
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 20; i++) begin
      step();
      probe();
      if (!busy) break;
    end
    check("drain_idle", busy, 1'b0);
  endtask

  string exp_seq = "DDDDFD";
  byte   got_ch;
  int    n_g;

  initial begin
    reset = 1'b0;
    clear();
    bus.if_req = 1'b1;
    bus.d_req  = 1'b1;
    probe();
    probe();
    check("rst_if_gnt", bus.if_gnt, 1'b0);
    check("rst_d_gnt", bus.d_gnt, 1'b0);
    check("rst_mem_en", bus.mem_en, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rvalids", {bus.if_rvalid, bus.d_rvalid}, 2'b00);
    check("rst_rdata", {bus.if_rdata, bus.d_rdata}, 64'h0);

    // Single fetch: grant at c0, data sampled at c2, rvalid at c3.
    step(); reset = 1'b1; clear();
    bus.if_req = 1'b1; bus.if_addr = 32'h10;
    probe();
    check("t1_if_gnt", bus.if_gnt, 1'b1);
    check("t1_mem", {bus.mem_en, bus.mem_we, bus.mem_be}, 6'b1_0_1111);
    check("t1_mem_addr", bus.mem_addr, 32'h10);
    step(); bus.if_req = 1'b0; probe();
    check("t1_busy_wait", busy, 1'b1);
    check("t1_mem_en_wait", bus.mem_en, 1'b0);
    step(); bus.mem_rdata = 32'hDEADBEEF; probe();
    step(); bus.mem_rdata = 32'h0; probe();
    check("t1_if_rvalid", bus.if_rvalid, 1'b1);
    check("t1_if_rdata", bus.if_rdata, 32'hDEADBEEF);
    check("t1_d_rvalid", bus.d_rvalid, 1'b0);
    step(); probe();
    check("t1_rvalid_pulse", bus.if_rvalid, 1'b0);
    check("t1_rdata_hold", bus.if_rdata, 32'hDEADBEEF);
    check("t1_idle", busy, 1'b0);

    // Simultaneous requests: data first, fetch granted in the RESP cycle.
    step();
    bus.if_req = 1'b1; bus.if_addr = 32'h20;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h40;
    probe();
    check("t2_d_gnt", {bus.d_gnt, bus.if_gnt}, 2'b10);
    check("t2_mem_addr", bus.mem_addr, 32'h40);
    step(); bus.d_req = 1'b0; probe();
    check("t2_no_gnt_wait", bus.if_gnt, 1'b0);
    step(); bus.mem_rdata = 32'hA5A50040; probe();
    step(); bus.mem_rdata = 32'h0; probe();
    check("t2_d_rvalid", bus.d_rvalid, 1'b1);
    check("t2_d_rdata", bus.d_rdata, 32'hA5A50040);
    check("t2_if_gnt_resp", bus.if_gnt, 1'b1);
    check("t2_mem_addr_resp", bus.mem_addr, 32'h20);
    step(); clear(); probe();
    drain();

    // Starvation: both held, grants D,D,D,D,F,D every MEM_LAT+1 cycles.
    step();
    bus.if_req = 1'b1; bus.if_addr = 32'h70;
    bus.d_req = 1'b1; bus.d_addr = 32'h60;
    n_g = 0;
    for (int c = 0; c < 30 && n_g < 6; c++) begin
      if (c > 0) step();
      probe();
      if (bus.d_gnt || bus.if_gnt) begin
        got_ch = bus.if_gnt ? "F" : "D";
        check($sformatf("t3_grant%0d", n_g), got_ch, exp_seq[n_g]);
        if (bus.if_gnt) check("t3_starve_at_fetch", dut.starve_cnt, 4'd4);
        if (n_g == 1) begin
          check("t3_spacing", c, 3);
          check("t3_rvalid_with_regrant", bus.d_rvalid, 1'b1);
        end
        n_g++;
      end
    end
    check("t3_grant_count", n_g, 6);
    step(); clear(); probe();
    drain();

    // Store with partial byte enables; ack carries zero data.
    step();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'b0011;
    bus.d_addr = 32'h8; bus.d_wdata = 32'h12345678;
    probe();
    check("t4_d_gnt", bus.d_gnt, 1'b1);
    check("t4_mem", {bus.mem_en, bus.mem_we, bus.mem_be}, 6'b1_1_0011);
    check("t4_mem_wdata", bus.mem_wdata, 32'h12345678);
    check("t4_mem_addr", bus.mem_addr, 32'h8);
    step(); clear(); probe();
    step(); bus.mem_rdata = 32'hFFFFFFFF; probe();
    step(); bus.mem_rdata = 32'h0; probe();
    check("t4_d_rvalid", bus.d_rvalid, 1'b1);
    check("t4_d_rdata", bus.d_rdata, 32'h0);
    drain();

    // Reset pulse in WAIT discards the access; pending fetch wins right after release.
    step(); bus.if_req = 1'b1; bus.if_addr = 32'h30; probe();
    check("t5_first_gnt", bus.if_gnt, 1'b1);
    step(); reset = 1'b0; probe();
    check("t5_busy_in_rst", busy, 1'b0);
    check("t5_gnt_in_rst", {bus.if_gnt, bus.mem_en}, 2'b00);
    step(); reset = 1'b1; probe();
    check("t5_gnt_after_release", bus.if_gnt, 1'b1);
    step(); bus.if_req = 1'b0; probe();
    check("t5_no_stale_rvalid", bus.if_rvalid, 1'b0);
    step(); bus.mem_rdata = 32'h55; probe();
    check("t5_no_rvalid_capture", bus.if_rvalid, 1'b0);
    step(); bus.mem_rdata = 32'h0; probe();
    check("t5_new_rvalid", bus.if_rvalid, 1'b1);
    check("t5_new_rdata", bus.if_rdata, 32'h55);
    drain();

    // d_req pulsed during WAIT is ignored and leaves starve_cnt alone.
    step();
    bus.if_req = 1'b1; bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h44;
    probe();
    check("t6_d_gnt", bus.d_gnt, 1'b1);
    step(); bus.if_req = 1'b0; bus.d_addr = 32'h50; probe();
    check("t6_no_gnt_wait", {bus.d_gnt, bus.mem_en}, 2'b00);
    step(); bus.d_req = 1'b0; bus.mem_rdata = 32'hCAFE0044; probe();
    check("t6_starve_kept", dut.starve_cnt, 4'd1);
    step(); bus.mem_rdata = 32'h0; probe();
    check("t6_d_rvalid", bus.d_rvalid, 1'b1);
    check("t6_d_rdata", bus.d_rdata, 32'hCAFE0044);
    check("t6_no_late_gnt", bus.d_gnt, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
